// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
// Shares one single-port synchronous RAM between instruction fetch (IF) and
// the MEM stage (loads/stores). Data requests win by default. A starvation
// counter forces an IF grant after STARVE_MAX consecutive data grants made
// while fetch was waiting. Each access is sequenced IDLE -> ISSUE ->
// (WAIT) -> RESP.
//
// Ports:
//   clk_i, rst_ni                  clock, async active-low reset
//   if_req_i/if_addr_i/if_flush_i  fetch request, address, branch flush
//   if_valid_o/if_rdata_o          fetch response pulse and data
//   if_stall_o                     freeze PC/IF (combinational)
//   mem_rd_req_i/mem_wr_req_i      load / store requests (level)
//   mem_addr_i/mem_wdata_i         load/store address and store data
//   mem_valid_o/mem_rdata_o        load data valid or store done, load data
//   mem_stall_o                    freeze whole pipeline (combinational)
//   ram_en_o/ram_we_o/ram_addr_o/ram_wdata_o/ram_rdata_i  RAM port
module mem_port_arbiter #(
  parameter int unsigned ADDR_W     = 8,
  parameter int unsigned DATA_W     = 8,
  parameter int unsigned MEM_LAT    = 1,
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              if_req_i,
  input  logic [ADDR_W-1:0] if_addr_i,
  input  logic              if_flush_i,
  output logic              if_valid_o,
  output logic [DATA_W-1:0] if_rdata_o,
  output logic              if_stall_o,
  input  logic              mem_rd_req_i,
  input  logic              mem_wr_req_i,
  input  logic [ADDR_W-1:0] mem_addr_i,
  input  logic [DATA_W-1:0] mem_wdata_i,
  output logic              mem_valid_o,
  output logic [DATA_W-1:0] mem_rdata_o,
  output logic              mem_stall_o,
  output logic              ram_en_o,
  output logic              ram_we_o,
  output logic [ADDR_W-1:0] ram_addr_o,
  output logic [DATA_W-1:0] ram_wdata_o,
  input  logic [DATA_W-1:0] ram_rdata_i
);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_e;

  localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);
  localparam logic [1:0] LAT_INIT   = 2'(MEM_LAT);

  state_e            state_q, state_d;
  logic              owner_mem_q, owner_mem_d;  // 1: MEM owns the access, 0: IF
  logic              op_wr_q, op_wr_d;          // 1: write, 0: read
  logic [1:0]        lat_q, lat_d;
  logic [3:0]        starve_q, starve_d;
  logic              discard_q, discard_d;
  logic              if_valid_q, if_valid_d;
  logic              mem_valid_q, mem_valid_d;
  logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
  logic [DATA_W-1:0] mem_rdata_q, mem_rdata_d;
  logic              ram_en_q, ram_en_d;
  logic              ram_we_q, ram_we_d;
  logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
  logic [DATA_W-1:0] ram_wdata_q, ram_wdata_d;

  logic mem_any_s;
  logic grant_if_s;
  logic discard_now_s;

  assign mem_any_s  = mem_rd_req_i | mem_wr_req_i;
  assign grant_if_s = if_req_i & (~mem_any_s | (starve_q == STARVE_LIM));
  // A flush seen in the same cycle as the capture must already suppress it.
  assign discard_now_s = discard_q | (if_flush_i & ~owner_mem_q);

  // Next-state and registered-output logic of the access sequencer.
  always_comb begin
    state_d     = state_q;
    owner_mem_d = owner_mem_q;
    op_wr_d     = op_wr_q;
    lat_d       = lat_q;
    starve_d    = starve_q;
    discard_d   = discard_q;
    if_valid_d  = 1'b0;
    mem_valid_d = 1'b0;
    if_rdata_d  = if_rdata_q;
    mem_rdata_d = mem_rdata_q;
    ram_en_d    = 1'b0;
    ram_we_d    = 1'b0;
    ram_addr_d  = ram_addr_q;
    ram_wdata_d = '0;
    case (state_q)
      S_IDLE: begin
        discard_d = 1'b0;
        if (grant_if_s) begin
          owner_mem_d = 1'b0;
          op_wr_d     = 1'b0;
          starve_d    = 4'd0;
          ram_en_d    = 1'b1;
          ram_addr_d  = if_addr_i;
          state_d     = S_ISSUE;
        end else if (mem_any_s) begin
          owner_mem_d = 1'b1;
          op_wr_d     = mem_wr_req_i;
          ram_en_d    = 1'b1;
          ram_we_d    = mem_wr_req_i;
          ram_addr_d  = mem_addr_i;
          ram_wdata_d = mem_wdata_i;
          state_d     = S_ISSUE;
          // Count only grants that made a waiting fetch wait longer.
          if (if_req_i) begin
            starve_d = (starve_q == STARVE_LIM) ? starve_q : starve_q + 4'd1;
          end else begin
            starve_d = 4'd0;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_ISSUE: begin
        discard_d = discard_now_s;
        if (op_wr_q) begin
          mem_valid_d = 1'b1;
          state_d     = S_RESP;
        end else begin
          lat_d   = LAT_INIT;
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        discard_d = discard_now_s;
        lat_d     = lat_q - 2'd1;
        if (lat_q <= 2'd1) begin
          state_d = S_RESP;
          if (owner_mem_q) begin
            mem_valid_d = 1'b1;
            mem_rdata_d = ram_rdata_i;
          end else if (!discard_now_s) begin
            if_valid_d = 1'b1;
            if_rdata_d = ram_rdata_i;
          end else begin
            if_valid_d = 1'b0;
          end
        end else begin
          state_d = S_WAIT;
        end
      end
      S_RESP: begin
        discard_d = 1'b0;
        state_d   = S_IDLE;
      end
      default: begin
        discard_d = 1'b0;
        state_d   = S_IDLE;
      end
    endcase
  end

  // State and output registers; reset clears every output at once.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= S_IDLE;
      owner_mem_q <= 1'b0;
      op_wr_q     <= 1'b0;
      lat_q       <= 2'd0;
      starve_q    <= 4'd0;
      discard_q   <= 1'b0;
      if_valid_q  <= 1'b0;
      mem_valid_q <= 1'b0;
      if_rdata_q  <= '0;
      mem_rdata_q <= '0;
      ram_en_q    <= 1'b0;
      ram_we_q    <= 1'b0;
      ram_addr_q  <= '0;
      ram_wdata_q <= '0;
    end else begin
      state_q     <= state_d;
      owner_mem_q <= owner_mem_d;
      op_wr_q     <= op_wr_d;
      lat_q       <= lat_d;
      starve_q    <= starve_d;
      discard_q   <= discard_d;
      if_valid_q  <= if_valid_d;
      mem_valid_q <= mem_valid_d;
      if_rdata_q  <= if_rdata_d;
      mem_rdata_q <= mem_rdata_d;
      ram_en_q    <= ram_en_d;
      ram_we_q    <= ram_we_d;
      ram_addr_q  <= ram_addr_d;
      ram_wdata_q <= ram_wdata_d;
    end
  end

  assign if_valid_o  = if_valid_q;
  assign if_rdata_o  = if_rdata_q;
  assign mem_valid_o = mem_valid_q;
  assign mem_rdata_o = mem_rdata_q;
  assign ram_en_o    = ram_en_q;
  assign ram_we_o    = ram_we_q;
  assign ram_addr_o  = ram_addr_q;
  assign ram_wdata_o = ram_wdata_q;
  assign if_stall_o  = if_req_i & ~if_valid_q;
  assign mem_stall_o = (mem_rd_req_i | mem_wr_req_i) & ~mem_valid_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
module tb_mem_port_arbiter;
  localparam int LAT  = 2;
  localparam int SMAX = 2;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       if_req = 1'b0, if_flush = 1'b0;
  logic [7:0] if_addr = 8'h00;
  logic       if_valid, if_stall;
  logic [7:0] if_rdata;
  logic       mem_rd_req = 1'b0, mem_wr_req = 1'b0;
  logic [7:0] mem_addr = 8'h00, mem_wdata = 8'h00;
  logic       mem_valid, mem_stall;
  logic [7:0] mem_rdata;
  logic       ram_en, ram_we;
  logic [7:0] ram_addr, ram_wdata, ram_rdata;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mem_port_arbiter #(.ADDR_W(8), .DATA_W(8), .MEM_LAT(LAT), .STARVE_MAX(SMAX)) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .if_req_i(if_req), .if_addr_i(if_addr), .if_flush_i(if_flush),
    .if_valid_o(if_valid), .if_rdata_o(if_rdata), .if_stall_o(if_stall),
    .mem_rd_req_i(mem_rd_req), .mem_wr_req_i(mem_wr_req),
    .mem_addr_i(mem_addr), .mem_wdata_i(mem_wdata),
    .mem_valid_o(mem_valid), .mem_rdata_o(mem_rdata), .mem_stall_o(mem_stall),
    .ram_en_o(ram_en), .ram_we_o(ram_we), .ram_addr_o(ram_addr),
    .ram_wdata_o(ram_wdata), .ram_rdata_i(ram_rdata)
  );

  // RAM model: fixed contents loaded on the first edge, LAT-cycle read pipe.
  logic [7:0] ram_m [256];
  logic [7:0] pipe  [LAT];
  logic       ram_loaded = 1'b0;
  assign ram_rdata = pipe[LAT-1];

  always @(posedge clk) begin
    if (!ram_loaded) begin
      for (int i = 0; i < 256; i++) ram_m[i] <= 8'(i * 3 + 1);
      ram_m[8'h10] <= 8'hA5;
      ram_m[8'h11] <= 8'h77;
      ram_m[8'h12] <= 8'h5E;
      ram_m[8'h30] <= 8'hC3;
      ram_loaded   <= 1'b1;
    end else if (ram_en && ram_we) begin
      ram_m[ram_addr] <= ram_wdata;
    end
    if (ram_en) pipe[0] <= ram_m[ram_addr];
    for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    if_req = 1'b0; if_flush = 1'b0; mem_rd_req = 1'b0; mem_wr_req = 1'b0;
    for (int i = 0; i < n; i++) next_cycle();
  endtask

  // Single fetch from cycle 0; request dropped the cycle after if_valid.
  task automatic fetch(input string tag, input logic [7:0] a, input logic [7:0] d);
    if_addr = a;
    for (int c = 0; c <= LAT + 3; c++) begin
      if_req = (c <= LAT + 2);
      @(negedge clk);
      check({tag, "_en"},    32'(ram_en),   32'(c == 1));
      check({tag, "_valid"}, 32'(if_valid), 32'(c == LAT + 2));
      check({tag, "_stall"}, 32'(if_stall), 32'(c < LAT + 2));
      if (c == 1) check({tag, "_addr"}, 32'(ram_addr), 32'(a));
      if (c == 1) check({tag, "_we"}, 32'(ram_we), 32'd0);
      if (c == LAT + 2) check({tag, "_rdata"}, 32'(if_rdata), 32'(d));
      next_cycle();
    end
    idle(1);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, got running expected done");
    $fatal(1, "timeout");
  end

  initial begin
    // Reset state.
    next_cycle();
    @(negedge clk);
    check("rst_en", 32'(ram_en), 32'd0);
    check("rst_valid", 32'({if_valid, mem_valid}), 32'd0);
    check("rst_stall", 32'({if_stall, mem_stall}), 32'd0);
    next_cycle();
    rst_n = 1'b1;
    idle(2);

    // Plain fetch of 0x10.
    fetch("fetch10", 8'h10, 8'hA5);

    // Store 0x3C to 0x20.
    mem_addr = 8'h20; mem_wdata = 8'h3C;
    for (int c = 0; c <= 3; c++) begin
      mem_wr_req = (c <= 2);
      @(negedge clk);
      check("st_we",    32'(ram_we),    32'(c == 1));
      check("st_valid", 32'(mem_valid), 32'(c == 2));
      check("st_stall", 32'(mem_stall), 32'(c < 2));
      if (c == 1) check("st_wdata", 32'(ram_wdata), 32'h3C);
      if (c == 2) check("st_wdata0", 32'(ram_wdata), 32'h00);
      next_cycle();
    end
    idle(1);

    // Load back 0x20.
    mem_addr = 8'h20;
    for (int c = 0; c <= LAT + 3; c++) begin
      mem_rd_req = (c <= LAT + 2);
      @(negedge clk);
      check("ld_valid", 32'(mem_valid), 32'(c == LAT + 2));
      check("ld_we", 32'(ram_we), 32'd0);
      if (c == LAT + 2) check("ld_rdata", 32'(mem_rdata), 32'h3C);
      next_cycle();
    end
    idle(1);

    // Simultaneous fetch and load: MEM first, then IF.
    mem_addr = 8'h30; if_addr = 8'h11;
    for (int c = 0; c <= 10; c++) begin
      mem_rd_req = (c <= LAT + 2);
      if_req     = (c <= 2 * LAT + 5);
      @(negedge clk);
      check("sim_en",     32'(ram_en),    32'(c == 1 || c == LAT + 4));
      check("sim_mvalid", 32'(mem_valid), 32'(c == LAT + 2));
      check("sim_ivalid", 32'(if_valid),  32'(c == 2 * LAT + 5));
      if (c == 1) check("sim_addr_mem", 32'(ram_addr), 32'h30);
      if (c == LAT + 4) check("sim_addr_if", 32'(ram_addr), 32'h11);
      if (c == LAT + 2) check("sim_mrdata", 32'(mem_rdata), 32'hC3);
      if (c == 2 * LAT + 5) check("sim_irdata", 32'(if_rdata), 32'h77);
      next_cycle();
    end
    idle(1);

    // Starvation guard with STARVE_MAX=2: MEM, MEM, IF, MEM.
    mem_addr = 8'h30; if_addr = 8'h12;
    for (int c = 0; c <= 20; c++) begin
      mem_rd_req = (c <= 19);
      if_req     = (c <= 14);
      @(negedge clk);
      check("stv_en", 32'(ram_en), 32'(c == 1 || c == 6 || c == 11 || c == 16));
      check("stv_mvalid", 32'(mem_valid), 32'(c == 4 || c == 9 || c == 19));
      check("stv_ivalid", 32'(if_valid), 32'(c == 14));
      if (c == 1 || c == 6 || c == 16) check("stv_addr_mem", 32'(ram_addr), 32'h30);
      if (c == 11) check("stv_addr_if", 32'(ram_addr), 32'h12);
      if (c == 14) check("stv_irdata", 32'(if_rdata), 32'h5E);
      next_cycle();
    end
    idle(1);

    // Flush during WAIT of a fetch of 0x10: no pulse, data unchanged.
    if_addr = 8'h10;
    for (int c = 0; c <= 6; c++) begin
      if_req   = (c <= 2);
      if_flush = (c == 2);
      @(negedge clk);
      check("fl_valid", 32'(if_valid), 32'd0);
      check("fl_rdata", 32'(if_rdata), 32'h5E);
      next_cycle();
    end
    idle(1);
    fetch("fetch11", 8'h11, 8'h77);

    // Reset during a store ISSUE: write enable drops at once.
    mem_addr = 8'h40; mem_wdata = 8'h99; mem_wr_req = 1'b1;
    next_cycle();
    check("rsti_we_pre", 32'(ram_we), 32'd1);
    rst_n = 1'b0;
    #1;
    check("rsti_we", 32'(ram_we), 32'd0);
    check("rsti_en", 32'(ram_en), 32'd0);
    check("rsti_wdata", 32'(ram_wdata), 32'd0);
    check("rsti_mstall", 32'(mem_stall), 32'd1);
    mem_wr_req = 1'b0;
    next_cycle();
    rst_n = 1'b1;
    idle(2);

    // Reset mid-WAIT of a load: everything cleared, no valid afterwards.
    mem_addr = 8'h30; mem_rd_req = 1'b1;
    next_cycle();
    next_cycle();
    rst_n = 1'b0;
    #1;
    check("rstw_addr", 32'(ram_addr), 32'd0);
    check("rstw_mrdata", 32'(mem_rdata), 32'd0);
    check("rstw_irdata", 32'(if_rdata), 32'd0);
    check("rstw_mvalid", 32'(mem_valid), 32'd0);
    mem_rd_req = 1'b0;
    next_cycle();
    rst_n = 1'b1;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      check("rstw_novalid", 32'({mem_valid, if_valid, ram_en}), 32'd0);
      next_cycle();
    end
    fetch("fetch_post", 8'h10, 8'hA5);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Shares the single-port synchronous RAM between the instruction-fetch stage and the MEM stage (loads/stores) of the pipeline. It arbitrates the two requesters with fixed data-first priority and a starvation guard for fetch, and sequences each RAM access through issue, wait and response phases. It drives the stall signals that freeze PC/IF or the whole pipeline while an access is outstanding. It sits beside the hazard controller, and its stalls are ORed with that controller's stall outputs at the top level.

## Interface
- ADDR_W, 8, RAM address width
- DATA_W, 8, RAM data width
- MEM_LAT, 1, RAM read latency in cycles (1..3), counted from the cycle ram_en is high
- STARVE_MAX, 4, consecutive data grants allowed while if_req waits (1..15)

- clk  in  1  single clock; all state updates on rising edge
- rst  in  1  reset, asynchronous, active-low
- if_req  in  1  fetch request; level, held until if_valid or flush
- if_addr  in  ADDR_W  fetch address; stable while if_req
- if_flush  in  1  branch clear; cancels the fetch in flight
- if_valid  out  1  one-cycle pulse, if_rdata valid
- if_rdata  out  DATA_W  fetched word
- if_stall  out  1  freeze PC/IF
- mem_rd_req  in  1  load request; level
- mem_wr_req  in  1  store request; level
- mem_addr  in  ADDR_W  load/store address
- mem_wdata  in  DATA_W  store data
- mem_valid  out  1  one-cycle pulse; load data valid, or store done
- mem_rdata  out  DATA_W  load data
- mem_stall  out  1  freeze entire pipeline
- ram_en, ram_we  out  1  RAM enable / write enable
- ram_addr  out  ADDR_W  RAM address
- ram_wdata  out  DATA_W  RAM write data
- ram_rdata  in  DATA_W  RAM read data

## Operation
- States: IDLE, ISSUE, WAIT, RESP. Owner register: IF or MEM. Op register: RD or WR.
- IDLE: at each rising edge, evaluate the requests.
  - A data request wins unless starve_cnt == STARVE_MAX and if_req is high.
  - mem_wr_req beats mem_rd_req when both are high.
  - On a grant: latch owner, op, addr and wdata; go to ISSUE.
- ISSUE (1 cycle): ram_en=1, ram_addr/ram_wdata come from the latched values, ram_we=1 only for WR.
  - RD goes next to WAIT with lat_cnt=MEM_LAT.
  - WR goes next to RESP.
- WAIT: decrement lat_cnt each cycle. On the cycle lat_cnt==1, capture ram_rdata into the owner's rdata register and go to RESP.
- RESP (1 cycle): pulse the owner's valid, then go to IDLE. Requests are ignored in RESP, because requesters drop req the cycle after valid.
- starve_cnt (4 bits):
  - +1 on each MEM grant made while if_req is high, saturating at STARVE_MAX.
  - Cleared on any IF grant.
  - Cleared when a MEM grant is made with if_req low.
- Flush:
  - if_flush high during ISSUE/WAIT/RESP with owner IF sets a discard flag. The RAM access completes, if_valid stays 0 and if_rdata is unchanged; the flag clears on return to IDLE.
  - if_flush in IDLE has no effect; the fetch stage re-presents if_req with the new address.
- if_stall = if_req & ~if_valid. mem_stall = (mem_rd_req | mem_wr_req) & ~mem_valid. Both are combinational.
- Reset (rst low, any state, mid-access included): state=IDLE, starve_cnt=0, discard=0. All outputs go to 0 immediately, including ram_we, so no partial write continues. The stall outputs still follow their equations.

## Timing
- Request high in IDLE cycle 0 → ISSUE in cycle 1 → WAIT in cycles 2..MEM_LAT+1 → valid in cycle MEM_LAT+2. With MEM_LAT=1, a read returns in cycle 3.
- Write: ISSUE in cycle 1, mem_valid in cycle 2.
- The earliest next grant is sampled at the end of the IDLE cycle after RESP.
  - Read throughput: 1 per MEM_LAT+3 cycles.
  - Write throughput: 1 per 3 cycles.
- if_rdata/mem_rdata hold their last captured value until the next capture.
- ram_* outputs are registered; they are 0 outside ISSUE except ram_addr, which holds its value.

## Test plan
- Reset: assert rst low mid-WAIT with MEM_LAT=2 → all outputs 0 at once; after release, state is IDLE and no valid pulse appears.
- Fetch only, MEM_LAT=1, if_addr=0x10, RAM[0x10]=0xA5, request in cycle 0 → ram_en in cycle 1; if_valid=1 and if_rdata=0xA5 in cycle 3; if_stall high in cycles 0..2.
- Simultaneous if_req and mem_rd_req in cycle 0 → MEM granted first (mem_valid in cycle 3); IF granted next (ISSUE in cycle 5); starve_cnt increments to 1, then clears.
- Starvation, STARVE_MAX=2: mem_rd_req held continuously with if_req high → the grant sequence is MEM, MEM, IF, MEM, …
- Store: mem_wr_req with addr=0x20, wdata=0x3C → ram_we=1 for exactly one cycle (cycle 1), mem_valid in cycle 2; a subsequent load of 0x20 returns 0x3C.
- Flush: if_flush pulsed during WAIT of a fetch → no if_valid pulse and if_rdata unchanged; the next fetch of 0x11 returns normally.
